chacha_ks_arbiter: RTL

- Round-robin scheduler sharing one `chacha_core` keystream engine between two requester channels, e.g. a UART encrypt path and a decrypt path.
- Keeps an independent 64-bit block counter per channel and drives the core's `init` and `ctr` inputs.
- Captures each 512-bit keystream block and returns it to the granted channel with an acknowledge.
- Sits between the UART byte-buffer FSMs and `chacha_core`; key, IV and rounds stay wired directly to the core.

---
 rtl/chacha_ks_arbiter_if.sv | 26 ++
 rtl/chacha_ks_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/chacha_ks_arbiter_if.sv
// Requester-side bus of chacha_ks_arbiter.
// Carries the per-channel block requests and acks, the counter write port
// and the returned keystream block.
// master: the UART byte-buffer side. slave: the arbiter.
interface chacha_ks_arbiter_if;
  logic         req0;
  logic         req1;
  logic         ack0;
  logic         ack1;
  logic         ctr_wr;
  logic         ctr_wr_ch;
  logic [63:0]  ctr_wr_data;
  logic [511:0] ks_out;
  logic         ks_ch;
  logic         ks_valid;

  modport master (
    output req0, req1, ctr_wr, ctr_wr_ch, ctr_wr_data,
    input  ack0, ack1, ks_out, ks_ch, ks_valid
  );

  modport slave (
    input  req0, req1, ctr_wr, ctr_wr_ch, ctr_wr_data,
    output ack0, ack1, ks_out, ks_ch, ks_valid
  );
endinterface

// File: rtl/chacha_ks_arbiter.sv
// Round-robin scheduler that shares one chacha_core between two keystream
// requesters. It keeps a 64-bit block counter per channel, drives the
// core's init and ctr inputs, and returns each captured 512-bit block to
// the granted channel with a one-cycle ack.
// Optional build macro CHACHA_ARB_TIMEOUT_EN: abort S_WAIT after
// TIMEOUT_CYC cycles and raise the sticky err flag.
module chacha_ks_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  chacha_ks_arbiter_if.slave      ks_bus,
  output logic                    core_init,
  output logic                    core_next,
  output logic [63:0]             core_ctr,
  input  logic                    core_ready,
  input  logic [511:0]            core_data_out,
  input  logic                    core_data_out_valid,
  output logic                    err
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_WAIT, S_DONE} state_t;

  state_t       state_q, state_d;
  logic         gnt_q;
  logic         last_gnt_q;
  logic [63:0]  ctr_q [2];
  logic [63:0]  core_ctr_q;
  logic [511:0] ks_out_q;
  logic         ks_ch_q;
  logic         seen_low_q;
  logic         pick;
  logic         grant;
  logic         capture;
  logic         timeout;
  logic         ack0_c, ack1_c, ks_valid_c;

  // Channel selection and capture qualification
  always_comb begin
    pick    = (ks_bus.req0 && ks_bus.req1) ? ~last_gnt_q : ks_bus.req1;
    grant   = core_ready && (ks_bus.req0 || ks_bus.req1);
    capture = (state_q == S_WAIT) && core_data_out_valid && seen_low_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and one-cycle strobes
  always_comb begin
    state_d    = state_q;
    core_init  = 1'b0;
    ks_valid_c = 1'b0;
    ack0_c     = 1'b0;
    ack1_c     = 1'b0;
    unique case (state_q)
      S_IDLE: if (grant) state_d = S_INIT;
      S_INIT: begin
        core_init = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (capture)      state_d = S_DONE;
        else if (timeout) state_d = S_IDLE;
      end
      S_DONE: begin
        ks_valid_c = 1'b1;
        ack0_c     = ~gnt_q;
        ack1_c     = gnt_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant, counters, stale-valid tracking and keystream capture
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      ctr_q[0]   <= '0;
      ctr_q[1]   <= '0;
      core_ctr_q <= '0;
      ks_out_q   <= '0;
      ks_ch_q    <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && grant) begin
        gnt_q      <= pick;
        core_ctr_q <= ctr_q[pick];
      end
      if (state_q == S_INIT)
        seen_low_q <= 1'b0;
      else if (state_q == S_WAIT && !core_data_out_valid)
        seen_low_q <= 1'b1;
      if (capture) begin
        ks_out_q <= core_data_out;
        ks_ch_q  <= gnt_q;
      end
      if (state_q == S_DONE) begin
        ctr_q[gnt_q] <= ctr_q[gnt_q] + 64'd1;
        last_gnt_q   <= gnt_q;
      end
      if (timeout)
        last_gnt_q <= gnt_q;
      // Placed after the increment so a same-cycle write to that channel wins.
      if (ks_bus.ctr_wr)
        ctr_q[ks_bus.ctr_wr_ch] <= ks_bus.ctr_wr_data;
    end
  end

`ifdef CHACHA_ARB_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_CYC + 1);

  logic [WCW-1:0] wait_cnt_q;
  logic           err_q;

  assign timeout = (state_q == S_WAIT) && !capture &&
                   (wait_cnt_q == WCW'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  // Wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == S_INIT)      wait_cnt_q <= '0;
      else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + WCW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign core_next       = 1'b0;
  assign core_ctr        = core_ctr_q;
  assign ks_bus.ks_out   = ks_out_q;
  assign ks_bus.ks_ch    = ks_ch_q;
  assign ks_bus.ks_valid = ks_valid_c;
  assign ks_bus.ack0     = ack0_c;
  assign ks_bus.ack1     = ack1_c;

endmodule
